// File: rtl/CPU_Param.sv
// Shared CPU constants: exception code sentinel, issue-queue FSM encodings, bubble payload.
// Pure declarations; no timing or backpressure of its own.
package CPU_Param;

    localparam logic [4:0] EXC_NONE = 5'd31;

    // All-zero instruction word decodes as sll $0,$0,0, a harmless bubble.
    localparam logic [63:0] NOP_PAYLOAD_DEFAULT = 64'h0;

    typedef enum logic {
        RUN     = 1'b0,
        BLOCKED = 1'b1
    } iq_state_t;

endpackage

// File: rtl/issue_queue.sv
// Decode-to-execute FIFO issue queue; one-cycle push-to-head latency, no empty bypass.
// Backpressure: in_ready drops when full, blocked by an exception entry, or flushing; hold stalls pop only.
module issue_queue
    import CPU_Param::*;
#(
    parameter int                 DATA_W      = 64,
    parameter int                 DEPTH       = 4,
    parameter logic [DATA_W-1:0]  NOP_PAYLOAD = DATA_W'(NOP_PAYLOAD_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_err,
    input  logic [4:0]                 in_excode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_err,
    output logic [4:0]                 out_excode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("issue_queue: DEPTH must be a power of two in 2..16");
    end

    logic [DATA_W-1:0] r_data [DEPTH];
    logic              r_err  [DEPTH];
    logic [4:0]        r_exc  [DEPTH];

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    iq_state_t         r_state;

    logic              w_push;
    logic              w_pop;
    logic              w_in_rdy;
    logic              w_out_vld;

    assign w_in_rdy  = (r_count < CNT_W'(DEPTH)) && (r_state == RUN) && !flush;
    assign w_out_vld = (r_count != '0) && !hold && !flush;
    assign w_push    = in_valid && w_in_rdy;
    assign w_pop     = w_out_vld && out_ready;

    assign in_ready   = w_in_rdy;
    assign out_valid  = w_out_vld;
    assign out_data   = w_out_vld ? r_data[r_rptr] : NOP_PAYLOAD;
    assign out_err    = w_out_vld ? r_err[r_rptr]  : 1'b0;
    assign out_excode = w_out_vld ? r_exc[r_rptr]  : EXC_NONE;
    assign count      = r_count;

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= in_data;
            r_err[r_wptr]  <= in_err;
            r_exc[r_wptr]  <= in_excode;
        end
    end

    // Pointers are exactly PTR_W bits so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= RUN;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // An excepting entry stops intake until the pipeline is flushed.
            if (w_push && in_err) begin
                r_state <= BLOCKED;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue at DEPTH=4, DATA_W=64 with hand-computed expectations.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_err;
    logic [4:0]  in_excode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_err;
    logic [4:0]  out_excode;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    issue_queue #(.DATA_W(64), .DEPTH(4), .NOP_PAYLOAD(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .hold       (hold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_err     (in_err),
        .in_excode  (in_excode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_excode (out_excode),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after a further settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b0; in_data = '0; in_err = 1'b0; in_excode = 5'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_count",   64'(count),      64'd0);
        chk("rst_ovalid",  64'(out_valid),  64'd0);
        chk("rst_odata",   out_data,        64'h0);
        chk("rst_oerr",    64'(out_err),    64'd0);
        chk("rst_oexc",    64'(out_excode), 64'd31);
        chk("rst_iready",  64'(in_ready),   64'd1);
        reset = 1'b0;
        tick();

        // Fill to full, then drain in order.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 64'hA + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("full_count",  64'(count),     64'd4);
        chk("full_iready", 64'(in_ready),  64'd0);
        chk("full_head",   out_data,       64'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_data", out_data, 64'hA + 64'(i));
            tick();
        end
        settle();
        chk("drain_count", 64'(count),    64'd0);
        chk("drain_odata", out_data,      64'h0);
        chk("drain_ovld",  64'(out_valid), 64'd0);

        // Streaming push+pop with pointer wrap.
        in_valid = 1'b1;
        in_data  = 64'h1;
        tick();
        for (int i = 2; i <= 8; i++) begin
            in_data = 64'(i);
            settle();
            chk("stream_data",  out_data,   64'(i - 1));
            chk("stream_count", 64'(count), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("stream_last", out_data, 64'h8);
        tick();
        chk("stream_empty", 64'(count), 64'd0);

        // Exception entry blocks intake until flush.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 64'h5; in_err = 1'b1; in_excode = 5'd10;
        tick();
        in_data = 64'h6; in_err = 1'b0; in_excode = 5'd0;
        settle();
        chk("blk_iready", 64'(in_ready), 64'd0);
        chk("blk_count",  64'(count),    64'd1);
        tick();
        chk("blk_ignored", 64'(count),      64'd1);
        chk("blk_oerr",    64'(out_err),    64'd1);
        chk("blk_oexc",    64'(out_excode), 64'd10);
        chk("blk_odata",   out_data,        64'h5);
        out_ready = 1'b1;
        tick();
        chk("blk_drained", 64'(count),      64'd0);
        chk("blk_exc31",   64'(out_excode), 64'd31);
        chk("blk_still",   64'(in_ready),   64'd0);
        tick();
        chk("blk_nopush",  64'(count),      64'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("blk_unblock", 64'(in_ready), 64'd1);

        // Flush discards queued entries and a same-cycle push.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 64'h11; tick();
        in_data = 64'h22; tick();
        in_data = 64'h33; tick();
        in_valid = 1'b0;
        settle();
        chk("fl_count3", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 64'h44;
        settle();
        chk("fl_ovld_during", 64'(out_valid), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("fl_count",  64'(count),     64'd0);
        chk("fl_ovld",   64'(out_valid), 64'd0);
        chk("fl_iready", 64'(in_ready),  64'd1);
        chk("fl_odata",  out_data,       64'h0);
        in_valid = 1'b1; in_data = 64'h55;
        tick();
        in_valid = 1'b0;
        settle();
        chk("fl_newhead", out_data, 64'h55);
        out_ready = 1'b1;
        tick();
        chk("fl_popped", 64'(count), 64'd0);

        // Hold freezes the head.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 64'h66; tick();
        in_data = 64'h77; tick();
        in_valid = 1'b0;
        hold = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_ovld",  64'(out_valid), 64'd0);
            chk("hold_odata", out_data,       64'h0);
            chk("hold_count", 64'(count),     64'd2);
            tick();
        end
        hold = 1'b0;
        settle();
        chk("hold_rel_head", out_data, 64'h66);
        tick();
        chk("hold_rel_count", 64'(count), 64'd1);
        chk("hold_rel_next",  out_data,   64'h77);
        tick();
        chk("hold_empty", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Reset while blocked with two entries.
        in_valid = 1'b1;
        in_data = 64'h99; tick();
        in_data = 64'hAA; in_err = 1'b1; in_excode = 5'd3; tick();
        in_valid = 1'b0; in_err = 1'b0; in_excode = 5'd0;
        settle();
        chk("rb_count",  64'(count),    64'd2);
        chk("rb_iready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rb_count0", 64'(count),      64'd0);
        chk("rb_exc",    64'(out_excode), 64'd31);
        chk("rb_run",    64'(in_ready),   64'd1);
        chk("rb_ovld",   64'(out_valid),  64'd0);
        in_valid = 1'b1; in_data = 64'hBB;
        tick();
        in_valid = 1'b0;
        settle();
        chk("rb_newhead", out_data, 64'hBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
